// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load and single-step manual operation.
// It also runs automatic multi-step bursts: hold, shift right, shift left or rotate right.
// A burst latches its mode and step count when it starts. It then runs one step per cycle
// and gives a one-cycle done pulse when it finishes. A load or a reset aborts a running
// burst without any done pulse.
module universal_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [WIDTH-1:0]             D,
    input  logic [1:0]                   mode,
    input  logic                         en,
    input  logic                         sin_r,
    input  logic                         sin_l,
    input  logic                         burst_start,
    input  logic [$clog2(WIDTH+1)-1:0]   burst_len,
    output logic [WIDTH-1:0]             Q,
    output logic                         sout_r,
    output logic                         sout_l,
    output logic                         busy,
    output logic                         done
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      burst_mode;
    logic [CW-1:0]   clamped_len;

    // One register step for a given operation. Shifts and ORs are used instead of
    // part-selects so that a one-bit register is still handled correctly.
    function automatic logic [WIDTH-1:0] step_value(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             s_r,
        input logic             s_l
    );
        logic [WIDTH-1:0] top_r;
        logic [WIDTH-1:0] top_rot;
        logic [WIDTH-1:0] low_l;
        top_r              = '0;
        top_r[WIDTH-1]     = s_r;
        top_rot            = '0;
        top_rot[WIDTH-1]   = cur[0];
        low_l              = '0;
        low_l[0]           = s_l;
        case (op)
            2'b01:   step_value = (cur >> 1) | top_r;
            2'b10:   step_value = (cur << 1) | low_l;
            2'b11:   step_value = (cur >> 1) | top_rot;
            default: step_value = cur;
        endcase
    endfunction

    // A burst never runs for more steps than the register is wide.
    always_comb begin
        clamped_len = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
    end

    // Main FSM. The priority order is reset, then load, then a burst step, then
    // burst start, then a manual step.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q          <= RESET_VALUE;
            state      <= IDLE;
            count      <= '0;
            burst_mode <= 2'b00;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                Q     <= D;
                state <= IDLE;
                count <= '0;
            end else if (state == BURST) begin
                Q     <= step_value(burst_mode, Q, sin_r, sin_l);
                count <= count - ONE;
                if (count == ONE) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end else if (burst_start) begin
                if (clamped_len == '0) begin
                    done <= 1'b1;
                end else begin
                    burst_mode <= mode;
                    count      <= clamped_len;
                    state      <= BURST;
                end
            end else if (en) begin
                Q <= step_value(mode, Q, sin_r, sin_l);
            end
        end
    end

    assign sout_r = Q[0];
    assign sout_l = Q[WIDTH-1];
    assign busy   = (state == BURST);

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register with WIDTH=8 and RESET_VALUE=8'hFF.
// It runs a set of directed scenarios first and then a randomized phase. All outputs are
// checked every cycle against an arithmetic reference model.
module tb_universal_shift_register;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RV    = 8'hFF;

    logic       clk = 1'b0;
    logic       rst, load, en, sin_r, sin_l, burst_start;
    logic [7:0] D;
    logic [1:0] mode;
    logic [3:0] burst_len;
    logic [7:0] Q;
    logic       sout_r, sout_l, busy, done;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int m_q;
    bit m_busy;
    int m_rem;
    int m_mode;
    bit m_done;

    universal_shift_register #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst), .load(load), .D(D), .mode(mode), .en(en),
        .sin_r(sin_r), .sin_l(sin_l), .burst_start(burst_start), .burst_len(burst_len),
        .Q(Q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int modelStep(int q, int md, bit sr, bit sl);
        case (md)
            1:       return (q / 2) + (sr ? 128 : 0);
            2:       return ((q * 2) % 256) + (sl ? 1 : 0);
            3:       return (q / 2) + ((q % 2) * 128);
            default: return q;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ld, input logic [7:0] d,
                                 input logic [1:0] md, input bit e, input bit sr,
                                 input bit sl, input bit bs, input logic [3:0] bl);
        rst = r; load = ld; D = d; mode = md; en = e;
        sin_r = sr; sin_l = sl; burst_start = bs; burst_len = bl;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelEdge();
        int n;
        bit dn;
        dn = 1'b0;
        if (rst) begin
            m_q = int'(RV); m_busy = 1'b0; m_rem = 0;
        end else if (load) begin
            m_q = int'(D); m_busy = 1'b0; m_rem = 0;
        end else if (m_busy) begin
            m_q   = modelStep(m_q, m_mode, sin_r, sin_l);
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                dn     = 1'b1;
            end
        end else if (burst_start) begin
            n = (int'(burst_len) > WIDTH) ? WIDTH : int'(burst_len);
            if (n == 0) dn = 1'b1;
            else begin
                m_busy = 1'b1; m_rem = n; m_mode = int'(mode);
            end
        end else if (en) begin
            m_q = modelStep(m_q, int'(mode), sin_r, sin_l);
        end
        m_done = dn;
    endtask

    task automatic checkOutput();
        chk("q",      {24'b0, Q},      m_q);
        chk("sout_r", {31'b0, sout_r}, m_q % 2);
        chk("sout_l", {31'b0, sout_l}, (m_q / 128) % 2);
        chk("busy",   {31'b0, busy},   {31'b0, m_busy});
        chk("done",   {31'b0, done},   {31'b0, m_done});
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        bit sl_stream [8];
        int steps;
        sl_stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        m_q = 0; m_busy = 1'b0; m_rem = 0; m_mode = 0; m_done = 1'b0;
        applyStimulus(1, 1, 8'h12, 2'b01, 1, 1, 1, 1, 4'd3);

        // Reset while load and burst_start are also high
        stepClock();
        chk("reset_q", {24'b0, Q}, 32'hFF);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);

        // Load A5, then one manual shift right
        applyStimulus(0, 1, 8'hA5, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b01, 1, 0, 0, 0, 4'd0);
        stepClock();
        chk("manual_sr_q", {24'b0, Q}, 32'h52);
        chk("manual_sr_sout_r", {31'b0, sout_r}, 32'd0);
        chk("manual_sr_sout_l", {31'b0, sout_l}, 32'd0);

        // Rotate burst of 3 from 81, with en high on the start cycle
        applyStimulus(0, 1, 8'h81, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b11, 1, 0, 0, 1, 4'd3);
        stepClock();
        chk("rot_start_q", {24'b0, Q}, 32'h81);
        chk("rot_start_busy", {31'b0, busy}, 32'd1);
        applyStimulus(0, 0, 8'h00, 2'b00, 1, 1, 1, 1, 4'd0);
        stepClock();
        stepClock();
        chk("rot_mid_q", {24'b0, Q}, 32'h60);
        stepClock();
        chk("rot_end_q", {24'b0, Q}, 32'h30);
        chk("rot_end_done", {31'b0, done}, 32'd1);
        chk("rot_end_busy", {31'b0, busy}, 32'd0);
        applyStimulus(0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();
        chk("rot_after_done", {31'b0, done}, 32'd0);

        // Shift-left burst of 8 fed by a serial stream
        applyStimulus(0, 1, 8'h00, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b10, 0, 0, 0, 1, 4'd8);
        stepClock();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 8'h00, 2'b01, 0, 1, sl_stream[i], 0, 4'd0);
            stepClock();
        end
        chk("stream_q", {24'b0, Q}, 32'hB2);
        chk("stream_done", {31'b0, done}, 32'd1);

        // Burst of 5 aborted by a load at step 2, then a zero-length start
        applyStimulus(0, 0, 8'h00, 2'b01, 0, 1, 0, 1, 4'd5);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b01, 0, 1, 0, 0, 4'd0);
        stepClock();
        applyStimulus(0, 1, 8'h3C, 2'b01, 0, 1, 0, 0, 4'd0);
        stepClock();
        chk("abort_load_q", {24'b0, Q}, 32'h3C);
        chk("abort_load_busy", {31'b0, busy}, 32'd0);
        chk("abort_load_done", {31'b0, done}, 32'd0);
        applyStimulus(0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) stepClock();
        applyStimulus(0, 0, 8'h00, 2'b10, 1, 1, 1, 1, 4'd0);
        stepClock();
        chk("zero_len_done", {31'b0, done}, 32'd1);
        chk("zero_len_q", {24'b0, Q}, 32'h3C);
        chk("zero_len_busy", {31'b0, busy}, 32'd0);
        applyStimulus(0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();

        // Burst of 6 aborted by reset at step 2
        applyStimulus(0, 1, 8'h5A, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b01, 0, 0, 0, 1, 4'd6);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b01, 0, 0, 0, 0, 4'd0);
        stepClock();
        applyStimulus(1, 0, 8'h00, 2'b01, 0, 0, 0, 0, 4'd0);
        stepClock();
        chk("abort_rst_q", {24'b0, Q}, 32'hFF);
        chk("abort_rst_busy", {31'b0, busy}, 32'd0);
        applyStimulus(0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 6; i++) stepClock();

        // burst_len=15 is clamped to 8 steps
        applyStimulus(0, 1, 8'h00, 2'b00, 0, 0, 0, 0, 4'd0);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b10, 0, 0, 1, 1, 4'd15);
        stepClock();
        applyStimulus(0, 0, 8'h00, 2'b00, 0, 0, 1, 0, 4'd0);
        steps = 0;
        while (done !== 1'b1 && steps < 20) begin
            stepClock();
            steps++;
        end
        chk("clamp_steps", steps, 32'd8);
        chk("clamp_q", {24'b0, Q}, 32'hFF);

        // Randomized phase: every output is checked each cycle against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                          8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom_range(0, 5) == 0, 4'($urandom));
            stepClock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 1.
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 Port clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port load  input  1  parallel load strobe.
REQ-006 Port D  input  WIDTH  parallel load data.
REQ-007 Port mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 rotate right.
REQ-008 Port en  input  1  single-step enable for the manual operation.
REQ-009 Port sin_r  input  1  bit entering Q[WIDTH-1] on shift right.
REQ-010 Port sin_l  input  1  bit entering Q[0] on shift left.
REQ-011 Port burst_start  input  1  start an automatic multi-step burst.
REQ-012 Port burst_len  input  CW = $clog2(WIDTH+1)  number of steps in the burst.
REQ-013 Port Q  output  WIDTH  register contents.
REQ-014 Port sout_r  output  1  Q[0], combinational from Q.
REQ-015 Port sout_l  output  1  Q[WIDTH-1], combinational from Q.
REQ-016 Port busy  output  1  high while a burst is in progress.
REQ-017 Port done  output  1  one-cycle pulse on burst completion.

Function
REQ-018 Step definitions: right: Q <= {sin_r, Q[W-1:1]}; left: Q <= {Q[W-2:0], sin_l}; rotate: Q <= {Q[0], Q[W-1:1]}; hold: unchanged.
REQ-019 WIDTH==1: right gives Q<=sin_r, left gives Q<=sin_l, rotate gives Q unchanged.
REQ-020 FSM states: IDLE, BURST; busy SHALL be 1 exactly in BURST.
REQ-021 Per-cycle priority SHALL be: rst > load > burst step (BURST) > burst_start (IDLE) > manual step (IDLE and en).
REQ-022 load: Q <= D next edge in any state; in BURST it SHALL abort the burst (-> IDLE, no done pulse).
REQ-023 IDLE, burst_start=1, burst_len=N>0: SHALL latch mode and N (N clamped to WIDTH), enter BURST; Q unchanged on that edge.
REQ-024 BURST: each cycle SHALL perform one step with the latched mode, decrement remaining count; live mode, en, burst_start ignored.
REQ-025 The edge performing the last step SHALL return to IDLE and assert done for the following cycle; busy falls on the same edge.
REQ-026 Latency: burst_start sampled at edge k -> steps at edges k+1..k+N, done=1 in cycle after edge k+N, busy=1 cycles k..k+N-1 (after edge k through edge k+N).
REQ-027 burst_start with burst_len=0 SHALL not enter BURST, leave Q unchanged, and pulse done for one cycle.
REQ-028 burst_start and en both high in IDLE: burst SHALL win; no manual step that cycle.
REQ-029 Burst with latched mode 00: Q held, counter still runs, done pulses after N cycles.
REQ-030 sin_r/sin_l SHALL be sampled live on every burst step (serial stream input).
REQ-031 done SHALL be 0 in all cycles other than those in REQ-025 and REQ-027.

Reset
REQ-032 rst=1 at a posedge SHALL set Q=RESET_VALUE, state IDLE, busy=0, done=0, count=0, regardless of load/burst activity.
REQ-033 rst mid-burst SHALL abort without a done pulse; outputs reflect reset from the next cycle.

Verification
REQ-034 WIDTH=8: rst, load D=8'hA5, en=1 mode=01 sin_r=0 one cycle -> Q=8'h52, sout_r=0, sout_l=0.
REQ-035 WIDTH=8: Q=8'h81, burst_start len=3 mode=11 -> busy 3 cycles, Q=8'h30 then done=1 one cycle, busy=0.
REQ-036 WIDTH=8: Q=8'h00, burst len=8 mode=10, sin_l stream 1,0,1,1,0,0,1,0 -> Q=8'hB2, done after 8 steps.
REQ-037 Burst len=5 mode=01 with load D=8'h3C at step 2 -> Q=8'h3C, busy=0, no done pulse; len=0 start -> done pulse, Q unchanged.
REQ-038 rst asserted at step 2 of a len=6 burst, RESET_VALUE=8'hFF -> Q=8'hFF, busy=0, done never pulses; burst_len=15 with WIDTH=8 -> clamped to 8 steps.
